// File: rtl/tt_lut_eval_seq.sv
// Programmable N-input truth-table evaluator with a 1-entry registered output stage
// and a sweep mode that dumps the table and compares it against an expected table.
module tt_lut_eval_seq #(
  parameter int N_IN = 3,
  localparam int TT_W = 2**N_IN,
  parameter logic [TT_W-1:0] TT_INIT = 8'hC7
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cfg_we,
  input  logic [TT_W-1:0] cfg_tt,
  output logic            cfg_err,
  input  logic            in_valid,
  input  logic [N_IN-1:0] in_vec,
  output logic            in_ready,
  output logic            out_valid,
  output logic            out_bit,
  output logic [N_IN-1:0] out_vec,
  output logic            out_last,
  input  logic            out_ready,
  input  logic            sweep_start,
  input  logic [TT_W-1:0] exp_tt,
  output logic            sweep_busy,
  output logic            sweep_done,
  output logic            sweep_match
);

  typedef enum logic [1:0] {IDLE = 2'd0, SWEEP = 2'd1, FLUSH = 2'd2} state_e;

  localparam logic [N_IN:0] CNT_LAST = (N_IN+1)'(TT_W-1);

  state_e          state, state_nxt;
  logic [TT_W-1:0] tt, dump_tt;
  logic [N_IN:0]   cnt;
  logic [N_IN-1:0] cidx;
  logic            ld, accept, sweep_go, sweep_ld, last_hs;

  assign cidx     = cnt[N_IN-1:0];
  assign ld       = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign sweep_go = (state == IDLE) && sweep_start;
  assign sweep_ld = (state == SWEEP) && ld;
  assign last_hs  = (state == FLUSH) && out_valid && out_ready && out_last;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sweep_start) state_nxt = SWEEP;
      SWEEP:   if (ld && cnt == CNT_LAST) state_nxt = FLUSH;
      FLUSH:   if (last_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready   = (state == IDLE) && ld && !sweep_start;
    sweep_busy = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tt          <= TT_INIT;
      dump_tt     <= '0;
      cnt         <= '0;
      out_valid   <= 1'b0;
      out_bit     <= 1'b0;
      out_vec     <= '0;
      out_last    <= 1'b0;
      cfg_err     <= 1'b0;
      sweep_done  <= 1'b0;
      sweep_match <= 1'b0;
    end else begin
      cfg_err    <= cfg_we && (state != IDLE);
      sweep_done <= last_hs;
      // Table write happens on the sweep_start edge too, so the sweep sees the new table.
      if (state == IDLE && cfg_we) tt <= cfg_tt;
      if (sweep_go) begin
        cnt         <= '0;
        dump_tt     <= '0;
        sweep_match <= 1'b0;
      end
      if (accept) begin
        out_bit   <= tt[in_vec];
        out_vec   <= in_vec;
        out_last  <= 1'b0;
        out_valid <= 1'b1;
      end else if (sweep_ld) begin
        out_vec       <= cidx;
        out_bit       <= tt[cidx];
        dump_tt[cidx] <= tt[cidx];
        out_last      <= (cnt == CNT_LAST);
        out_valid     <= 1'b1;
        if (cnt != CNT_LAST) cnt <= cnt + 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (last_hs) sweep_match <= (dump_tt == exp_tt);
    end
  end

endmodule

// File: tb/tb_tt_lut_eval_seq.sv
// Scoreboard bench for tt_lut_eval_seq: an N_IN=3 instance for stream/sweep/reset
// scenarios and an N_IN=4 instance swept under random backpressure.
module tb_tt_lut_eval_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, cfg_we, in_valid, out_ready, sweep_start;
  logic [7:0] cfg_tt, exp_tt;
  logic [2:0] in_vec, out_vec;
  logic       cfg_err, in_ready, out_valid, out_bit, out_last, sweep_busy, sweep_done, sweep_match;

  logic        b_cfg_we, b_in_valid, b_out_ready, b_sweep_start;
  logic [15:0] b_cfg_tt, b_exp_tt;
  logic [3:0]  b_in_vec, b_out_vec;
  logic        b_cfg_err, b_in_ready, b_out_valid, b_out_bit, b_out_last;
  logic        b_sweep_busy, b_sweep_done, b_sweep_match;

  tt_lut_eval_seq dut_a (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_tt(cfg_tt), .cfg_err(cfg_err),
    .in_valid(in_valid), .in_vec(in_vec), .in_ready(in_ready),
    .out_valid(out_valid), .out_bit(out_bit), .out_vec(out_vec), .out_last(out_last),
    .out_ready(out_ready), .sweep_start(sweep_start), .exp_tt(exp_tt),
    .sweep_busy(sweep_busy), .sweep_done(sweep_done), .sweep_match(sweep_match)
  );

  tt_lut_eval_seq #(.N_IN(4), .TT_INIT(16'hBEEF)) dut_b (
    .clk(clk), .rst_n(rst_n), .cfg_we(b_cfg_we), .cfg_tt(b_cfg_tt), .cfg_err(b_cfg_err),
    .in_valid(b_in_valid), .in_vec(b_in_vec), .in_ready(b_in_ready),
    .out_valid(b_out_valid), .out_bit(b_out_bit), .out_vec(b_out_vec), .out_last(b_out_last),
    .out_ready(b_out_ready), .sweep_start(b_sweep_start), .exp_tt(b_exp_tt),
    .sweep_busy(b_sweep_busy), .sweep_done(b_sweep_done), .sweep_match(b_sweep_match)
  );

  typedef struct {
    logic [3:0] vec;
    logic       b;
    logic       last;
    int         cyc;   // accept cycle, -1 when latency is not checked
  } beat_t;

  beat_t qa[$], qb[$];
  beat_t ea, eb;
  int checks = 0, failures = 0, cyc = 0;
  int done_a = 0, err_a = 0, beats_a = 0, done_b = 0;
  logic       pv_a = 1'b0, pv_b = 1'b0;
  logic [4:0] pk_a, pk_b;
  logic [7:0] tt_m;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h @cyc %0d", tag, got, exp, cyc);
    end
  endtask

  // Output monitors: scoreboard pop on handshake, plus hold-stability under backpressure.
  always @(negedge clk) begin
    if (rst_n) begin
      if (pv_a) begin
        chk("a_hold_valid", out_valid, 1);
        chk("a_hold_data", {out_last, out_bit, out_vec}, pk_a);
      end
      if (out_valid && out_ready) begin
        beats_a++;
        if (qa.size() == 0) chk("a_unexpected_beat", 1, 0);
        else begin
          ea = qa.pop_front();
          chk("a_vec", out_vec, ea.vec);
          chk("a_bit", out_bit, ea.b);
          chk("a_last", out_last, ea.last);
          if (ea.cyc >= 0) chk("a_latency", cyc - ea.cyc, 1);
        end
      end
      if (sweep_done) done_a++;
      if (cfg_err) err_a++;
    end
    pv_a = rst_n && out_valid && !out_ready;
    pk_a = {out_last, out_bit, out_vec};
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (pv_b) begin
        chk("b_hold_valid", b_out_valid, 1);
        chk("b_hold_data", {b_out_last, b_out_bit, b_out_vec[2:0]}, pk_b);
      end
      if (b_out_valid && b_out_ready) begin
        if (qb.size() == 0) chk("b_unexpected_beat", 1, 0);
        else begin
          eb = qb.pop_front();
          chk("b_vec", b_out_vec, eb.vec);
          chk("b_bit", b_out_bit, eb.b);
          chk("b_last", b_out_last, eb.last);
        end
      end
      if (b_sweep_done) done_b++;
    end
    pv_b = rst_n && b_out_valid && !b_out_ready;
    pk_b = {b_out_last, b_out_bit, b_out_vec[2:0]};
  end

  always @(posedge clk) begin
    #1 b_out_ready = 1'($urandom_range(0, 1));
  end

  task automatic send(input logic [2:0] v, input bit chk_lat);
    in_valid = 1'b1; in_vec = v;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    chk("a_in_ready", in_ready, 1);
    qa.push_back('{vec: 4'(v), b: tt_m[v], last: 1'b0, cyc: chk_lat ? cyc : -1});
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic start_sweep(input logic we, input logic [7:0] ctt, input logic [7:0] tbl);
    sweep_start = 1'b1; cfg_we = we; cfg_tt = ctt;
    @(negedge clk);
    chk("a_busy_before_start", sweep_busy, 0);
    chk("a_ready_on_start", in_ready, 0);
    for (int i = 0; i < 8; i++) qa.push_back('{vec: 4'(i), b: tbl[i], last: (i == 7), cyc: -1});
    @(posedge clk); #1;
    sweep_start = 1'b0; cfg_we = 1'b0;
  endtask

  task automatic wait_done(input logic m);
    int d0 = done_a;
    int k;
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      if (done_a > d0) break;
    end
    chk("a_done_seen", (k < 100), 1);
    chk("a_sweep_match", sweep_match, m);
    repeat (3) @(negedge clk);
    chk("a_done_pulses", done_a - d0, 1);
    chk("a_busy_after", sweep_busy, 0);
    chk("a_queue_empty", qa.size(), 0);
  endtask

  initial begin
    int b0, d0, e0, k;
    rst_n = 1'b0; cfg_we = 1'b0; cfg_tt = '0; in_valid = 1'b0; in_vec = '0;
    out_ready = 1'b1; sweep_start = 1'b0; exp_tt = '0;
    b_cfg_we = 1'b0; b_cfg_tt = '0; b_in_valid = 1'b0; b_in_vec = '0;
    b_sweep_start = 1'b0; b_exp_tt = '0;
    tt_m = 8'hC7;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_a_outputs", {out_valid, out_bit, out_vec, out_last, cfg_err, sweep_done, sweep_match, sweep_busy}, 0);
    chk("rst_b_outputs", {b_out_valid, b_out_vec, b_out_last, b_sweep_busy, b_sweep_match}, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Back-to-back stream with the reset table
    for (int i = 0; i < 8; i++) send(3'(i), 1'b1);
    repeat (3) @(posedge clk);
    chk("stream_drained", qa.size(), 0);

    // Backpressure: vec 3 held for 3 cycles
    #1 send(3'd3, 1'b0);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_valid", out_valid, 1);
      chk("bp_bit", out_bit, 0);
      chk("bp_vec", out_vec, 3);
      chk("bp_in_ready", in_ready, 0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    send(3'd6, 1'b0);
    repeat (3) @(posedge clk); #1;

    // cfg_we together with sweep_start: sweep uses new table
    exp_tt = 8'h96;
    start_sweep(1'b1, 8'h96, 8'h96);
    tt_m = 8'h96;
    wait_done(1'b1);
    @(posedge clk); #1 exp_tt = 8'h97;
    start_sweep(1'b0, 8'h00, 8'h96);
    wait_done(1'b0);

    // cfg_we during SWEEP is rejected with a single cfg_err pulse
    @(posedge clk); #1 exp_tt = 8'h96;
    e0 = err_a;
    start_sweep(1'b0, 8'h00, 8'h96);
    cfg_we = 1'b1; cfg_tt = 8'hFF;
    @(posedge clk); #1 cfg_we = 1'b0;
    wait_done(1'b1);
    chk("cfg_err_pulses", err_a - e0, 1);
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) send(3'(i), 1'b1);
    repeat (3) @(posedge clk); #1;
    chk("old_table_stream_drained", qa.size(), 0);

    // Reset mid-sweep aborts without a done pulse
    start_sweep(1'b0, 8'h00, 8'h96);
    b0 = beats_a;
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (beats_a - b0 >= 4) break;
    end
    chk("mid_sweep_beats", (k < 50), 1);
    d0 = done_a;
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    qa.delete();
    tt_m = 8'hC7;
    @(negedge clk);
    chk("midrst_outputs", {out_valid, out_bit, out_vec, out_last, cfg_err, sweep_done, sweep_match, sweep_busy}, 0);
    repeat (10) @(negedge clk);
    chk("midrst_no_done", done_a - d0, 0);
    @(posedge clk); #1 exp_tt = 8'hC7;
    start_sweep(1'b0, 8'h00, 8'hC7);
    wait_done(1'b1);

    // N_IN=4 sweep under random out_ready
    @(posedge clk); #1;
    b_exp_tt = 16'hBEEF;
    d0 = done_b;
    b_sweep_start = 1'b1;
    @(negedge clk);
    chk("b_ready_on_start", b_in_ready, 0);
    for (int i = 0; i < 16; i++) begin
      logic [15:0] t;
      t = 16'hBEEF;
      qb.push_back('{vec: 4'(i), b: t[i], last: (i == 15), cyc: -1});
    end
    @(posedge clk); #1 b_sweep_start = 1'b0;
    for (k = 0; k < 400; k++) begin
      @(negedge clk);
      if (done_b > d0) break;
    end
    chk("b_done_seen", (k < 400), 1);
    chk("b_sweep_match", b_sweep_match, 1);
    chk("b_queue_empty", qb.size(), 0);

    repeat (5) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
